multi_bowl_feeder_ctrl: RTL and testbench

Next-generation feeding controller that serves N_BOWLS bowls from one shared hopper. Per-bowl feed and play requests are latched, arbitrated round-robin with feed ahead of play, and dispensed one bowl at a time, with a jam timeout. Includes a daily per-bowl play limit, leftover warnings, and refill/cap interlocks. It sits between the UI/timer blocks (targets, init_done, newday, timesup) and the gate drivers and LED block.

---
 rtl/multi_bowl_feeder_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_multi_bowl_feeder_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_bowl_feeder_ctrl.sv
// Multi-bowl feeder sequencer: latches feed/play requests, grants one bowl at a time
// round-robin (feed ahead of play), and runs the gate with jam, refill and daily play limits.
//
// state      | meaning
// INIT_WAIT  | waiting for UI init_done
// IDLE       | evaluate newday, refill interlock, then feed/play grants
// NEWDAY     | clear play counters and warnings
// REFILL     | hopper low or cap open; wait until both clear
// CHECK      | compute goal and timer for the granted bowl
// DISPENSE   | gate open until goal, timeout or refill
// CLOSE      | gate shut, remember last served bowl
module multi_bowl_feeder_ctrl #(
  parameter int N_BOWLS      = 4,
  parameter int W_WIDTH      = 10,
  parameter int PLAY_LIMIT   = 15,
  parameter int PLAY_PORTION = 1,
  parameter int TIMEOUT_CYC  = 1023
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         init_done,
  input  logic                         newday,
  input  logic [N_BOWLS-1:0]           timesup,
  input  logic [N_BOWLS-1:0]           pedal,
  input  logic [N_BOWLS*W_WIDTH-1:0]   food_weight,
  input  logic [N_BOWLS*W_WIDTH-1:0]   target_weight,
  input  logic                         refill_needed,
  input  logic                         cap_open,
  output logic [N_BOWLS-1:0]           gate,
  output logic [$clog2(N_BOWLS)-1:0]   active_bowl,
  output logic                         busy,
  output logic [N_BOWLS-1:0]           warning,
  output logic                         play_fail,
  output logic                         jam_fault,
  output logic                         refill_wait
);
  localparam int B_W    = $clog2(N_BOWLS);
  localparam int PC_RAW = $clog2(PLAY_LIMIT + 1);
  localparam int PC_W   = (PC_RAW < 4) ? 4 : PC_RAW;
  localparam int T_W    = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_INIT_WAIT, S_IDLE, S_NEWDAY, S_REFILL, S_CHECK, S_DISPENSE, S_CLOSE
  } state_t;

  state_t               r_state, w_next;
  logic [N_BOWLS-1:0]   r_feed_pend, r_play_pend, r_warning;
  logic                 r_new_pend, r_mode_play;
  logic [B_W-1:0]       r_last, r_bowl;
  logic [W_WIDTH-1:0]   r_goal;
  logic [T_W-1:0]       r_timer;
  logic [PC_W-1:0]      r_play_cnt [N_BOWLS];

  logic [W_WIDTH-1:0]   w_weight, w_target, w_goal, w_play_goal;
  logic [W_WIDTH:0]     w_play_sum;
  logic [B_W-1:0]       w_grant_idx;
  logic                 w_grant_valid, w_grant_play;
  logic [N_BOWLS-1:0]   w_feed_clr, w_play_clr, w_retry;
  logic                 w_cnt_inc, w_warn_set, w_play_fail, w_jam;

  assign w_weight    = food_weight[r_bowl*W_WIDTH +: W_WIDTH];
  assign w_target    = target_weight[r_bowl*W_WIDTH +: W_WIDTH];
  assign w_play_sum  = {1'b0, w_weight} + (W_WIDTH+1)'(PLAY_PORTION);
  assign w_play_goal = w_play_sum[W_WIDTH] ? '1 : w_play_sum[W_WIDTH-1:0];
  assign w_goal      = r_mode_play ? w_play_goal : w_target;

  // Round-robin search from the bowl after last_served, whole feed vector before play.
  always_comb begin
    int idx;
    w_grant_valid = 1'b0;
    w_grant_play  = 1'b0;
    w_grant_idx   = '0;
    idx           = 0;
    for (int k = 1; k <= N_BOWLS; k++) begin
      idx = int'(r_last) + k;
      if (idx >= N_BOWLS) idx = idx - N_BOWLS;
      if (!w_grant_valid && r_feed_pend[idx]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = B_W'(idx);
      end
    end
    for (int k = 1; k <= N_BOWLS; k++) begin
      idx = int'(r_last) + k;
      if (idx >= N_BOWLS) idx = idx - N_BOWLS;
      if (!w_grant_valid && r_play_pend[idx]) begin
        w_grant_valid = 1'b1;
        w_grant_play  = 1'b1;
        w_grant_idx   = B_W'(idx);
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_feed_clr  = '0;
    w_play_clr  = '0;
    w_retry     = '0;
    w_cnt_inc   = 1'b0;
    w_warn_set  = 1'b0;
    w_play_fail = 1'b0;
    w_jam       = 1'b0;
    case (r_state)
      S_INIT_WAIT: if (init_done) w_next = S_IDLE;
      S_IDLE: begin
        if (r_new_pend) w_next = S_NEWDAY;
        else if (refill_needed || cap_open) w_next = S_REFILL;
        else if (w_grant_valid) begin
          w_next = S_CHECK;
          if (w_grant_play) w_play_clr[w_grant_idx] = 1'b1;
          else              w_feed_clr[w_grant_idx] = 1'b1;
        end
      end
      S_NEWDAY: w_next = S_IDLE;
      S_REFILL: if (!refill_needed && !cap_open) w_next = S_IDLE;
      S_CHECK: begin
        if (r_mode_play && r_play_cnt[r_bowl] == PC_W'(PLAY_LIMIT)) begin
          w_play_fail = 1'b1;
          w_next      = S_IDLE;
        end else begin
          if (!r_mode_play && w_weight > w_target / W_WIDTH'(3)) w_warn_set = 1'b1;
          w_cnt_inc = r_mode_play;
          w_next    = (w_weight >= w_goal) ? S_CLOSE : S_DISPENSE;
        end
      end
      S_DISPENSE: begin
        if (w_weight >= r_goal) w_next = S_CLOSE;
        else if (r_timer == '0) begin
          w_jam  = 1'b1;
          w_next = S_CLOSE;
        end else if (refill_needed) begin
          if (!r_mode_play) w_retry[r_bowl] = 1'b1;
          w_next = S_CLOSE;
        end
      end
      S_CLOSE: w_next = S_IDLE;
      default: w_next = S_INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_INIT_WAIT;
      r_feed_pend <= '0;
      r_play_pend <= '0;
      r_new_pend  <= 1'b0;
      r_warning   <= '0;
      r_mode_play <= 1'b0;
      r_last      <= B_W'(N_BOWLS - 1);
      r_bowl      <= '0;
      r_goal      <= '0;
      r_timer     <= '0;
      for (int i = 0; i < N_BOWLS; i++) r_play_cnt[i] <= '0;
    end else begin
      r_state     <= w_next;
      r_feed_pend <= (r_feed_pend & ~w_feed_clr) | timesup | w_retry;
      r_play_pend <= (r_play_pend & ~w_play_clr) | pedal;
      r_new_pend  <= (r_new_pend && r_state != S_NEWDAY) || newday;
      if (r_state == S_IDLE && w_next == S_CHECK) begin
        r_bowl      <= w_grant_idx;
        r_mode_play <= w_grant_play;
      end
      if (r_state == S_CHECK) begin
        r_goal  <= w_goal;
        r_timer <= T_W'(TIMEOUT_CYC);
      end
      if (r_state == S_DISPENSE && r_timer != '0) r_timer <= r_timer - 1'b1;
      if (r_state == S_CLOSE) r_last <= r_bowl;
      if (r_state == S_NEWDAY) begin
        r_warning <= '0;
        for (int i = 0; i < N_BOWLS; i++) r_play_cnt[i] <= '0;
      end else begin
        if (w_warn_set) r_warning[r_bowl] <= 1'b1;
        if (w_cnt_inc)  r_play_cnt[r_bowl] <= r_play_cnt[r_bowl] + 1'b1;
      end
    end
  end

  assign busy        = (r_state == S_CHECK) || (r_state == S_DISPENSE) || (r_state == S_CLOSE);
  assign gate        = (r_state == S_DISPENSE) ? (N_BOWLS'(1) << r_bowl) : '0;
  assign active_bowl = busy ? r_bowl : '0;
  assign warning     = r_warning;
  assign play_fail   = w_play_fail;
  assign jam_fault   = w_jam;
  assign refill_wait = (r_state == S_REFILL);
endmodule

// File: tb/tb_multi_bowl_feeder_ctrl.sv
// Bench for multi_bowl_feeder_ctrl: directed scenarios plus randomized request batches
// checked against a serve-order / warning / play-limit reference model.
module tb_multi_bowl_feeder_ctrl;
  localparam int N = 4;
  localparam int W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, init_done, newday, refill_needed, cap_open;
  logic [N-1:0] timesup, pedal, gate, warning;
  logic [N*W-1:0] food_weight, target_weight;
  logic [1:0] active_bowl;
  logic busy, play_fail, jam_fault, refill_wait;

  multi_bowl_feeder_ctrl dut (
    .clk(clk), .reset(reset), .init_done(init_done), .newday(newday),
    .timesup(timesup), .pedal(pedal), .food_weight(food_weight),
    .target_weight(target_weight), .refill_needed(refill_needed), .cap_open(cap_open),
    .gate(gate), .active_bowl(active_bowl), .busy(busy), .warning(warning),
    .play_fail(play_fail), .jam_fault(jam_fault), .refill_wait(refill_wait)
  );

  int errors = 0, checks = 0;
  int wt[N], tgt[N], step[N];
  int obs[$], exp_q[$];
  int open_cnt[N];
  int pf_cnt, jam_cnt, multi_hot, exp_fail;
  logic prev_busy = 1'b0;
  int m_last, m_cnt[N];
  logic [N-1:0] m_warn;

  task automatic drive_w();
    for (int i = 0; i < N; i++) begin
      food_weight[i*W +: W]   = W'(wt[i]);
      target_weight[i*W +: W] = W'(tgt[i]);
    end
  endtask

  // One clock: sample at the falling edge, then let the plant pour into open bowls.
  task automatic tick();
    @(negedge clk);
    if (busy && !prev_busy) obs.push_back(int'(active_bowl));
    if ($countones(gate) > 1) multi_hot++;
    if (play_fail) pf_cnt++;
    if (jam_fault) jam_cnt++;
    for (int i = 0; i < N; i++)
      if (gate[i]) begin
        open_cnt[i]++;
        wt[i] = wt[i] + step[i];
        if (wt[i] > 1023) wt[i] = 1023;
      end
    prev_busy = busy;
    drive_w();
  endtask

  task automatic clear_mon();
    obs.delete();
    for (int i = 0; i < N; i++) open_cnt[i] = 0;
    pf_cnt = 0; jam_cnt = 0; multi_hot = 0;
  endtask

  task automatic pulse(input logic [N-1:0] f, input logic [N-1:0] p, input logic nd);
    timesup = f; pedal = p; newday = nd;
    tick();
    timesup = '0; pedal = '0; newday = 1'b0;
  endtask

  task automatic wait_quiet(input int bound);
    int low = 0, n = 0;
    while (low < 6 && n < bound) begin
      tick(); n++;
      if (busy || refill_wait) low = 0; else low++;
    end
    checks++;
    if (low < 6) begin
      errors++;
      $display("FAIL wait_quiet: still active after %0d cycles, expected idle", n);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    m_last = N - 1;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_warn = '0;
  endtask

  task automatic set_bowls(input int w0, input int t0, input int s0);
    for (int i = 0; i < N; i++) begin wt[i] = w0; tgt[i] = t0; step[i] = s0; end
    drive_w();
  endtask

  // Reference: requests in one batch are served feed-first, round-robin from the
  // bowl after the last one actually dispensed; refused plays do not move the pointer.
  task automatic model_batch(input logic [N-1:0] f, input logic [N-1:0] p, input logic nd);
    logic [N-1:0] fp, pp;
    int b, c;
    logic isplay;
    if (nd) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_warn = '0;
    end
    exp_q.delete(); exp_fail = 0;
    fp = f; pp = p;
    while (fp != 0 || pp != 0) begin
      b = -1; isplay = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (b < 0 && fp[c]) b = c;
      end
      if (b < 0) begin
        isplay = 1'b1;
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (b < 0 && pp[c]) b = c;
        end
      end
      exp_q.push_back(b);
      if (!isplay) begin
        fp[b] = 1'b0;
        if (wt[b] > tgt[b] / 3) m_warn[b] = 1'b1;
        m_last = b;
      end else begin
        pp[b] = 1'b0;
        if (m_cnt[b] == 15) exp_fail++;
        else begin m_cnt[b]++; m_last = b; end
      end
    end
  endtask

  task automatic check_order(input string name);
    int bad = 0;
    if (obs.size() != exp_q.size()) bad = 1;
    else for (int i = 0; i < obs.size(); i++) if (obs[i] != exp_q[i]) bad = 1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s order: got %0d serves first=%0d, expected %0d serves first=%0d",
               name, obs.size(), (obs.size() > 0) ? obs[0] : -1,
               exp_q.size(), (exp_q.size() > 0) ? exp_q[0] : -1);
    end
  endtask

  task automatic test_reset();
    init_done = 1'b0;
    set_bowls(90, 100, 4);
    do_reset();
    checks++;
    if ({gate, active_bowl, busy, warning, play_fail, jam_fault, refill_wait} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gate=%b bowl=%0d busy=%b warn=%b, expected all zero",
               gate, active_bowl, busy, warning);
    end
    clear_mon();
    pulse(4'b0010, 4'b0000, 1'b0);
    repeat (3) tick();
    checks++;
    if (obs.size() != 0) begin
      errors++;
      $display("FAIL init_wait_hold: %0d serves before init_done, expected 0", obs.size());
    end
    init_done = 1'b1;
    exp_q.delete(); exp_q.push_back(1);
    wait_quiet(500);
    check_order("init_latched");
  endtask

  task automatic test_feed_ramp();
    do_reset();
    set_bowls(0, 100, 0);
    wt[2] = 10; step[2] = 1; drive_w();
    clear_mon();
    pulse(4'b0100, 4'b0000, 1'b0);
    wait_quiet(500);
    checks++;
    if (open_cnt[2] != 90) begin
      errors++; $display("FAIL ramp_open_cycles: got %0d, expected 90", open_cnt[2]);
    end
    checks++;
    if (wt[2] != 100) begin
      errors++; $display("FAIL ramp_final_weight: got %0d, expected 100", wt[2]);
    end
    checks++;
    if (warning !== 4'b0000) begin
      errors++; $display("FAIL ramp_warning: got %b, expected 0000", warning);
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    set_bowls(20, 100, 4);
    clear_mon();
    model_batch(4'b1001, 4'b0010, 1'b0);
    pulse(4'b1001, 4'b0010, 1'b0);
    wait_quiet(1000);
    check_order("feed_before_play");
    checks++;
    if (exp_q.size() != 3 || exp_q[0] != 0 || exp_q[1] != 3 || exp_q[2] != 1 || multi_hot != 0) begin
      errors++;
      $display("FAIL arb_shape: multi_hot=%0d, expected order 0,3,1 with no multi-hot", multi_hot);
    end
    checks++;
    if (open_cnt[1] != 1) begin
      errors++; $display("FAIL arb_play_open: got %0d cycles, expected 1", open_cnt[1]);
    end
  endtask

  task automatic test_play_limit();
    do_reset();
    set_bowls(0, 0, 0);
    wt[1] = 5; step[1] = 1; drive_w();
    for (int k = 0; k < 16; k++) begin
      clear_mon();
      pulse(4'b0000, 4'b0010, 1'b0);
      wait_quiet(200);
      checks++;
      if (k < 15 && (open_cnt[1] != 1 || pf_cnt != 0)) begin
        errors++;
        $display("FAIL play_%0d: open=%0d fail=%0d, expected open=1 fail=0", k, open_cnt[1], pf_cnt);
      end else if (k == 15 && (open_cnt[1] != 0 || pf_cnt != 1)) begin
        errors++;
        $display("FAIL play_limit: open=%0d fail=%0d, expected open=0 fail=1", open_cnt[1], pf_cnt);
      end
    end
    checks++;
    if (wt[1] != 20) begin
      errors++; $display("FAIL play_weight: got %0d, expected 20", wt[1]);
    end
    pulse(4'b0000, 4'b0000, 1'b1);
    wait_quiet(100);
    clear_mon();
    pulse(4'b0000, 4'b0010, 1'b0);
    wait_quiet(200);
    checks++;
    if (open_cnt[1] != 1 || pf_cnt != 0 || wt[1] != 21) begin
      errors++;
      $display("FAIL play_after_newday: open=%0d fail=%0d wt=%0d, expected 1 0 21", open_cnt[1], pf_cnt, wt[1]);
    end
  endtask

  task automatic test_jam();
    do_reset();
    set_bowls(0, 50, 0);
    clear_mon();
    pulse(4'b0001, 4'b0000, 1'b0);
    wait_quiet(3000);
    checks++;
    if (open_cnt[0] != 1024) begin
      errors++; $display("FAIL jam_open_cycles: got %0d, expected 1024", open_cnt[0]);
    end
    checks++;
    if (jam_cnt != 1 || gate !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL jam_pulse: pulses=%0d gate=%b busy=%b, expected 1 0000 0", jam_cnt, gate, busy);
    end
  endtask

  task automatic test_refill();
    int c;
    do_reset();
    set_bowls(0, 200, 0);
    step[2] = 1;
    clear_mon();
    pulse(4'b0100, 4'b0000, 1'b0);
    c = 0;
    while (open_cnt[2] < 10 && c < 50) begin tick(); c++; end
    refill_needed = 1'b1;
    c = 0;
    while (gate[2] && c < 5) begin tick(); c++; end
    checks++;
    if (c > 2) begin
      errors++; $display("FAIL refill_gate_close: took %0d cycles, expected <= 2", c);
    end
    repeat (3) tick();
    checks++;
    if (refill_wait !== 1'b1) begin
      errors++; $display("FAIL refill_wait_on: got %b, expected 1", refill_wait);
    end
    cap_open = 1'b1; refill_needed = 1'b0;
    repeat (4) tick();
    checks++;
    if (refill_wait !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL refill_cap_hold: wait=%b busy=%b, expected 1 0", refill_wait, busy);
    end
    cap_open = 1'b0;
    clear_mon();
    exp_q.delete(); exp_q.push_back(2);
    wait_quiet(1000);
    check_order("refill_retry");
    checks++;
    if (wt[2] != 200) begin
      errors++; $display("FAIL refill_retry_weight: got %0d, expected 200", wt[2]);
    end
    wt[2] = 0; drive_w();
    pulse(4'b0100, 4'b0000, 1'b0);
    c = 0;
    while (!gate[2] && c < 20) begin tick(); c++; end
    reset = 1'b1;
    tick();
    checks++;
    if (gate !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_dispense: gate=%b busy=%b, expected 0000 0", gate, busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_warning();
    do_reset();
    set_bowls(0, 100, 4);
    wt[3] = 40; drive_w();
    pulse(4'b1000, 4'b0000, 1'b0);
    wait_quiet(500);
    checks++;
    if (warning !== 4'b1000) begin
      errors++; $display("FAIL warn_set: got %b, expected 1000", warning);
    end
    repeat (20) tick();
    checks++;
    if (warning !== 4'b1000) begin
      errors++; $display("FAIL warn_sticky: got %b, expected 1000", warning);
    end
    pulse(4'b0000, 4'b0000, 1'b1);
    wait_quiet(100);
    checks++;
    if (warning !== 4'b0000) begin
      errors++; $display("FAIL warn_newday_clear: got %b, expected 0000", warning);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] f, p;
    logic nd;
    do_reset();
    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < N; i++) begin
        tgt[i]  = $urandom_range(300, 60);
        wt[i]   = $urandom_range(tgt[i] / 2, 0);
        step[i] = 4;
      end
      drive_w();
      f  = N'($urandom);
      p  = N'($urandom | $urandom | $urandom);
      nd = ($urandom_range(15, 0) == 0);
      model_batch(f, p, nd);
      clear_mon();
      pulse(f, p, nd);
      wait_quiet(3000);
      check_order($sformatf("rnd%0d", r));
      checks++;
      if (pf_cnt != exp_fail) begin
        errors++; $display("FAIL rnd%0d play_fail: got %0d, expected %0d", r, pf_cnt, exp_fail);
      end
      checks++;
      if (warning !== m_warn) begin
        errors++; $display("FAIL rnd%0d warning: got %b, expected %b", r, warning, m_warn);
      end
      checks++;
      if (jam_cnt != 0 || multi_hot != 0) begin
        errors++; $display("FAIL rnd%0d gate_sanity: jam=%0d multi_hot=%0d, expected 0 0", r, jam_cnt, multi_hot);
      end
    end
  endtask

  initial begin
    reset = 1'b1; init_done = 1'b0; newday = 1'b0;
    timesup = '0; pedal = '0; refill_needed = 1'b0; cap_open = 1'b0;
    set_bowls(0, 0, 0);
    test_reset();
    test_feed_ramp();
    test_arbitration();
    test_play_limit();
    test_jam();
    test_refill();
    test_warning();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
